// File: rtl/vc_input_port.sv
// Virtual-channel input port: one circular flit FIFO per VC plus a per-VC
// route/VC-allocation FSM (IDLE -> REQ -> WAIT_VC -> ACTIVE) that gates pops.
module vc_input_port #(
  parameter  int NUM_VCS    = 2,
  parameter  int DEPTH      = 8,
  parameter  int FLIT_WIDTH = 40,
  localparam int VW         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [VW-1:0]                 in_vc,
  input  logic [FLIT_WIDTH-1:0]         in_flit,
  input  logic                          in_last,
  output logic [NUM_VCS-1:0]            available,
  output logic [NUM_VCS-1:0]            credit_out,
  output logic [NUM_VCS-1:0]            req_pipeline,
  input  logic [NUM_VCS-1:0]            pipeline_granted,
  input  logic [NUM_VCS-1:0]            pipeline_failed,
  input  logic [NUM_VCS-1:0]            vc_granted,
  input  logic [VW-1:0]                 final_vc,
  output logic [NUM_VCS-1:0]            active,
  output logic [NUM_VCS*VW-1:0]         buffer_vc,
  input  logic [NUM_VCS-1:0]            ren,
  output logic [NUM_VCS*FLIT_WIDTH-1:0] rdata,
  output logic [NUM_VCS-1:0]            rlast,
  output logic [NUM_VCS-1:0]            empty,
  input  logic [NUM_VCS-1:0]            flush,
  output logic [NUM_VCS-1:0]            overflow
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_VC,
    ST_ACTIVE
  } vc_state_e;

  logic [FLIT_WIDTH:0] mem_q    [NUM_VCS][DEPTH];
  logic [AW:0]         wr_ptr_q [NUM_VCS];
  logic [AW:0]         wr_ptr_d [NUM_VCS];
  logic [AW:0]         rd_ptr_q [NUM_VCS];
  logic [AW:0]         rd_ptr_d [NUM_VCS];
  vc_state_e           state_q  [NUM_VCS];
  vc_state_e           state_d  [NUM_VCS];
  logic [VW-1:0]       bvc_q    [NUM_VCS];
  logic [VW-1:0]       bvc_d    [NUM_VCS];
  logic [NUM_VCS-1:0]  ovf_q, ovf_d;
  logic [NUM_VCS-1:0]  credit_q;

  logic [NUM_VCS-1:0]  full, wr_hit, wr_en, pop_eff;
  logic [FLIT_WIDTH:0] head [NUM_VCS];

  // Occupancy flags, write/pop qualification and per-VC outputs.
  // NOTE: every signal written in an always_comb gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    empty        = '0;
    available    = '0;
    full         = '0;
    wr_hit       = '0;
    wr_en        = '0;
    pop_eff      = '0;
    rdata        = '0;
    rlast        = '0;
    active       = '0;
    req_pipeline = '0;
    buffer_vc    = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      head[v]      = mem_q[v][rd_ptr_q[v][AW-1:0]];
      empty[v]     = (wr_ptr_q[v] == rd_ptr_q[v]);
      full[v]      = (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]) &&
                     (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]);
      available[v] = ~full[v];
      wr_hit[v]    = in_valid && (in_vc == VW'(v));
      pop_eff[v]   = ren[v] && !empty[v] && (state_q[v] == ST_ACTIVE) && !flush[v];
      // A pop in the same cycle frees the slot, so a full VC can still accept.
      wr_en[v]     = wr_hit[v] && !flush[v] && (!full[v] || pop_eff[v]);
      rdata[v*FLIT_WIDTH +: FLIT_WIDTH] = head[v][FLIT_WIDTH-1:0];
      rlast[v]        = head[v][FLIT_WIDTH];
      active[v]       = (state_q[v] == ST_ACTIVE);
      req_pipeline[v] = (state_q[v] == ST_REQ);
      buffer_vc[v*VW +: VW] = bvc_q[v];
    end
  end

  // Next-state: pointers, sticky overflow and the per-VC allocation FSM.
  always_comb begin
    ovf_d = ovf_q;
    for (int v = 0; v < NUM_VCS; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      state_d[v]  = state_q[v];
      bvc_d[v]    = bvc_q[v];
      if (flush[v]) begin
        wr_ptr_d[v] = '0;
        rd_ptr_d[v] = '0;
        state_d[v]  = ST_IDLE;
      end else begin
        if (wr_en[v])   wr_ptr_d[v] = wr_ptr_q[v] + 1'b1;
        if (pop_eff[v]) rd_ptr_d[v] = rd_ptr_q[v] + 1'b1;
        if (wr_hit[v] && !wr_en[v]) ovf_d[v] = 1'b1;
        unique case (state_q[v])
          ST_IDLE:    if (!empty[v]) state_d[v] = ST_REQ;
          ST_REQ:     if (pipeline_granted[v]) state_d[v] = ST_WAIT_VC;
          ST_WAIT_VC: begin
            // A VC grant wins over a same-cycle pipeline failure.
            if (vc_granted[v]) begin
              state_d[v] = ST_ACTIVE;
              bvc_d[v]   = final_vc;
            end else if (pipeline_failed[v]) begin
              state_d[v] = ST_REQ;
            end
          end
          ST_ACTIVE:  if (pop_eff[v] && head[v][FLIT_WIDTH]) state_d[v] = ST_IDLE;
          default:    state_d[v] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q    <= '0;
      credit_q <= '0;
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        state_q[v]  <= ST_IDLE;
        bvc_q[v]    <= '0;
      end
    end else begin
      ovf_q    <= ovf_d;
      credit_q <= pop_eff;
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        state_q[v]  <= state_d[v];
        bvc_q[v]    <= bvc_d[v];
      end
    end
  end

  // NOTE: flit storage is deliberately not reset; the pointers define which
  // entries are valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (wr_en[v]) mem_q[v][wr_ptr_q[v][AW-1:0]] <= {in_last, in_flit};
    end
  end

  assign credit_out = credit_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/vc_input_port.md
VC_INPUT_PORT -- requirements
Module: vc_input_port

Interface
REQ-001 SHALL have parameter NUM_VCS, default 2, number of virtual channels (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, flits per VC FIFO (power of two, >=2).
REQ-003 SHALL have parameter FLIT_WIDTH, default 40, stored flit width.
REQ-004 SHALL have port: clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port: in_valid  input  1  flit present on input this cycle.
REQ-007 SHALL have port: in_vc  input  $clog2(NUM_VCS) (min 1)  target VC of input flit.
REQ-008 SHALL have port: in_flit  input  FLIT_WIDTH  flit data.
REQ-009 SHALL have port: in_last  input  1  tail-of-packet marker, stored with flit.
REQ-010 SHALL have port: available  output  NUM_VCS  VC FIFO not full.
REQ-011 SHALL have port: credit_out  output  NUM_VCS  one-cycle pulse per flit popped.
REQ-012 SHALL have port: req_pipeline  output  NUM_VCS  VC head flit requests route compute.
REQ-013 SHALL have port: pipeline_granted  input  NUM_VCS  route compute accepted request.
REQ-014 SHALL have port: pipeline_failed  input  NUM_VCS  downstream allocation failed; retry.
REQ-015 SHALL have port: vc_granted  input  NUM_VCS  output VC allocated.
REQ-016 SHALL have port: final_vc  input  $clog2(NUM_VCS) (min 1)  allocated output VC, valid with vc_granted.
REQ-017 SHALL have port: active  output  NUM_VCS  VC streaming packet to crossbar.
REQ-018 SHALL have port: buffer_vc  output  NUM_VCS*$clog2(NUM_VCS) (min 1 bit per VC)  latched output VC per VC.
REQ-019 SHALL have port: ren  input  NUM_VCS  pop head flit of VC.
REQ-020 SHALL have port: rdata  output  NUM_VCS*FLIT_WIDTH  head flit per VC.
REQ-021 SHALL have port: rlast  output  NUM_VCS  tail marker of head flit.
REQ-022 SHALL have port: empty  output  NUM_VCS  VC FIFO empty.
REQ-023 SHALL have port: flush  input  NUM_VCS  discard VC contents, return VC to IDLE.
REQ-024 SHALL have port: overflow  output  NUM_VCS  sticky: a write was dropped.

Function
REQ-025 SHALL implement one circular FIFO per VC; pointers $clog2(DEPTH)+1 bits with wrap bit; full = indices equal, wrap bits differ.
REQ-026 SHALL write {in_last,in_flit} into FIFO[in_vc] on in_valid; visible on rdata next cycle.
REQ-027 SHALL drop a write to a full VC with no same-cycle effective pop and set overflow[in_vc]; it stays set until reset.
REQ-028 SHALL accept a write to a full VC when the same VC pops in the same cycle; occupancy unchanged.
REQ-029 SHALL make a pop effective only when ren[v]=1, empty[v]=0 and VC v is ACTIVE; it is ignored otherwise.
REQ-030 SHALL pulse credit_out[v] exactly one cycle after each effective pop, and not for flushed or dropped flits.
REQ-031 SHALL drive available[v] and empty[v] combinationally from current occupancy.
REQ-032 SHALL run a per-VC FSM with states IDLE, REQ, WAIT_VC and ACTIVE.
REQ-033 IDLE SHALL go to REQ when the VC is non-empty.
REQ-034 REQ SHALL drive req_pipeline[v]=1 and go to WAIT_VC on pipeline_granted[v].
REQ-035 WAIT_VC SHALL latch final_vc into buffer_vc[v] and go to ACTIVE on vc_granted[v].
REQ-036 WAIT_VC SHALL go to REQ on pipeline_failed[v] if vc_granted[v] is low.
REQ-037 vc_granted[v] SHALL win over pipeline_failed[v] when both are asserted in the same cycle.
REQ-038 ACTIVE SHALL drive active[v]=1 and go to IDLE the cycle after an effective pop of a flit with last=1.
REQ-039 IDLE SHALL take one cycle before REQ, giving one bubble between packets.
REQ-040 SHALL ignore pipeline_granted, vc_granted and pipeline_failed for a VC not in the matching state.
REQ-041 flush[v] SHALL zero VC v pointers and return it to IDLE next cycle; it overrides a same-cycle write or pop to v.
REQ-042 SHALL keep VCs independent; a full or stalled VC SHALL NOT block writes or state of other VCs.

Reset
REQ-043 While rst=1 at a clock edge, all pointers SHALL be 0 and all FSMs IDLE.
REQ-044 While rst=1 at a clock edge, overflow, credit_out, req_pipeline, active and buffer_vc SHALL be 0.
REQ-045 While rst=1 at a clock edge, empty SHALL be all 1 and available all 1.
REQ-046 Reset mid-packet SHALL discard all stored flits, and no credit_out SHALL be issued for them.

Verification
REQ-047 Write 3 flits (last on 3rd) to VC0 -> req_pipeline[0]=1 two cycles after first write -> grant -> vc_granted with final_vc=1 -> active[0]=1, buffer_vc[0]=1 -> 3 pops -> 3 credit_out[0] pulses -> IDLE, empty[0]=1.
REQ-048 DEPTH=8: write 9 flits to VC1, no pops -> available[1]=0 after 8th -> 9th dropped, overflow[1]=1, VC0 unaffected.
REQ-049 Full VC0 in ACTIVE: write and pop in same cycle -> accepted, occupancy stays 8, one credit pulse.
REQ-050 WAIT_VC with pipeline_failed=1 -> REQ next cycle, req_pipeline reasserted; pipeline_failed and vc_granted together -> ACTIVE.
REQ-051 Fill 8 then pop 8, repeated 3 times (pointer wrap) -> data order preserved, 24 credits total.
REQ-052 Flush VC0 holding 5 flits while ACTIVE -> empty[0]=1 and IDLE next cycle, no credits; assert rst mid-packet -> all outputs at reset values.
